// File: rtl/trng_collector_pkg.sv
// Shared definitions for the TRNG entropy collector: FSM encoding and
// width helpers.
package trng_collector_pkg;

   // FSM state encoding, shared with the MMIO side.
   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_FULL = 2'd1,
      ST_FAIL = 2'd2
   } state_e;

   // Default word width delivered to the consumer.
   localparam int TRNG_WIDTH_DEF = 4;

   // Width of the repetition-count counter.
   localparam int RCT_W = 8;

   // Counter width for a modulo-n counter. Never returns less than 1 bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vn_debias.sv
// Von Neumann debiaser. Pairs consecutive strobed samples.
// 01 emits 0 and 10 emits 1. 00 and 11 are dropped.
module vn_debias (
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   input  logic bit_in,
   input  logic clear,
   output logic bit_out,
   output logic bit_vld
);

   logic second_q, second_d;
   logic first_q, first_d;

   // Pair toggle and first-bit capture. The output is valid on the second sample of a differing pair.
   always_comb begin
      second_d = second_q;
      first_d  = first_q;
      bit_out  = first_q;
      bit_vld  = 1'b0;
      if (clear) begin
         second_d = 1'b0;
      end else if (strobe) begin
         if (!second_q) begin
            first_d  = bit_in;
            second_d = 1'b1;
         end else begin
            second_d = 1'b0;
            bit_vld  = (first_q != bit_in);
         end
      end
   end

   // Pair state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         second_q <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         second_q <= second_d;
         first_q  <= first_d;
      end
   end

endmodule

// File: rtl/trng_collector.sv
// TRNG entropy collector. Synchronises a raw ring-oscillator bit, samples it
// periodically and debiases it. It packs the result into words, hands the words
// out over a req/valid handshake and locks up when the repetition-count test trips.
module trng_collector
   import trng_collector_pkg::*;
#(
   parameter int TRNG_WIDTH = TRNG_WIDTH_DEF,
   parameter int SAMPLE_DIV = 8,
   parameter int RCT_LIMIT  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  raw_bit,
   input  logic                  trng_req,
   output logic                  trng_valid,
   output logic [TRNG_WIDTH-1:0] trng_word,
   output logic                  word_ready,
   output logic                  health_fail
);

   localparam int DIV_W  = cnt_w(SAMPLE_DIV);
   localparam int BCNT_W = $clog2(TRNG_WIDTH + 1);

   logic                  sync1_q, sync1_d;
   logic                  raw_s_q, raw_s_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic                  prev_q, prev_d;
   logic [RCT_W-1:0]      rct_cnt_q, rct_cnt_d;
   logic                  health_fail_q, health_fail_d;
   state_e                state_q, state_d;
   logic [TRNG_WIDTH-1:0] word_sr_q, word_sr_d;
   logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                  word_ready_q, word_ready_d;
   logic                  trng_valid_q, trng_valid_d;
   logic [TRNG_WIDTH-1:0] trng_word_q, trng_word_d;

   logic strobe;
   logic trip;
   logic vn_clear;
   logic vn_bit;
   logic vn_vld;

   assign strobe = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
   // The trip is taken from the registered count, so it lands one cycle after the strobe that saturates it.
   assign trip   = (rct_cnt_q == RCT_W'(RCT_LIMIT));

   // Synchroniser, sample divider and repetition-count health test. These run in every state.
   always_comb begin
      sync1_d   = raw_bit;
      raw_s_d   = sync1_q;
      div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
      prev_d    = prev_q;
      rct_cnt_d = rct_cnt_q;
      if (strobe) begin
         prev_d = raw_s_q;
         if (raw_s_q == prev_q) begin
            if (rct_cnt_q != RCT_W'(RCT_LIMIT)) rct_cnt_d = rct_cnt_q + 1'b1;
         end else begin
            rct_cnt_d = RCT_W'(1);
         end
      end
   end

   // Debiaser only sees strobes while filling. It is cleared on the FULL->FILL handoff.
   vn_debias u_vn (
      .clk     (clk),
      .reset   (reset),
      .strobe  (strobe && (state_q == ST_FILL)),
      .bit_in  (raw_s_q),
      .clear   (vn_clear),
      .bit_out (vn_bit),
      .bit_vld (vn_vld)
   );

   // Packing FSM with the registered handshake outputs. A health trip overrides everything.
   always_comb begin
      state_d       = state_q;
      word_sr_d     = word_sr_q;
      bit_cnt_d     = bit_cnt_q;
      word_ready_d  = word_ready_q;
      trng_valid_d  = 1'b0;
      trng_word_d   = '0;
      vn_clear      = 1'b0;
      health_fail_d = health_fail_q | trip;
      case (state_q)
         ST_FILL: begin
            if (vn_vld) begin
               word_sr_d = (word_sr_q << 1) | TRNG_WIDTH'(vn_bit);
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_d == BCNT_W'(TRNG_WIDTH)) begin
                  state_d      = ST_FULL;
                  word_ready_d = 1'b1;
               end
            end
         end
         ST_FULL: begin
            if (trng_req && !health_fail_q) begin
               trng_valid_d = 1'b1;
               trng_word_d  = word_sr_q;
               state_d      = ST_FILL;
               word_sr_d    = '0;
               bit_cnt_d    = '0;
               word_ready_d = 1'b0;
               vn_clear     = 1'b1;
            end
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_FAIL;
         end
      endcase
      if (trip) begin
         state_d      = ST_FAIL;
         word_sr_d    = '0;
         bit_cnt_d    = '0;
         word_ready_d = 1'b0;
         trng_valid_d = 1'b0;
         trng_word_d  = '0;
         vn_clear     = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= 1'b0;
         raw_s_q       <= 1'b0;
         div_cnt_q     <= '0;
         prev_q        <= 1'b0;
         rct_cnt_q     <= '0;
         health_fail_q <= 1'b0;
         state_q       <= ST_FILL;
         word_sr_q     <= '0;
         bit_cnt_q     <= '0;
         word_ready_q  <= 1'b0;
         trng_valid_q  <= 1'b0;
         trng_word_q   <= '0;
      end else begin
         sync1_q       <= sync1_d;
         raw_s_q       <= raw_s_d;
         div_cnt_q     <= div_cnt_d;
         prev_q        <= prev_d;
         rct_cnt_q     <= rct_cnt_d;
         health_fail_q <= health_fail_d;
         state_q       <= state_d;
         word_sr_q     <= word_sr_d;
         bit_cnt_q     <= bit_cnt_d;
         word_ready_q  <= word_ready_d;
         trng_valid_q  <= trng_valid_d;
         trng_word_q   <= trng_word_d;
      end
   end

   assign trng_valid  = trng_valid_q;
   assign trng_word   = trng_word_q;
   assign word_ready  = word_ready_q;
   assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector. dut_a uses a fast sampler for the data-path scenarios.
// dut_b uses the default divider for the stuck-source health test.
module tb_trng_collector;

   logic       clk = 1'b0;
   logic       rst_a, raw_a, req_a, valid_a, ready_a, hf_a;
   logic [3:0] word_a;
   logic       rst_b, raw_b, req_b, valid_b, ready_b, hf_b;
   logic [3:0] word_b;

   int total = 0;
   int bad   = 0;
   int vcnt_a = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_w;

   always #5 clk = ~clk;

   trng_collector #(.TRNG_WIDTH(4), .SAMPLE_DIV(1), .RCT_LIMIT(32)) dut_a (
      .clk(clk), .reset(rst_a), .raw_bit(raw_a), .trng_req(req_a),
      .trng_valid(valid_a), .trng_word(word_a), .word_ready(ready_a), .health_fail(hf_a));

   trng_collector #(.TRNG_WIDTH(4), .SAMPLE_DIV(8), .RCT_LIMIT(32)) dut_b (
      .clk(clk), .reset(rst_b), .raw_bit(raw_b), .trng_req(req_b),
      .trng_valid(valid_b), .trng_word(word_b), .word_ready(ready_b), .health_fail(hf_b));

   // Reference debiaser: s[i] is the raw bit driven in cycle i after reset.
   function automatic logic [3:0] vn_word(input logic [31:0] s, input int n);
      logic [3:0] w = '0;
      int k = 0;
      for (int i = 0; i + 1 < n; i += 2)
         if (k < 4 && s[i] != s[i+1]) begin
            w = {w[2:0], s[i]};
            k++;
         end
      return w;
   endfunction

   // Scoreboard for dut_a: every valid pops an expected word, and the word must read 0 otherwise.
   always @(negedge clk) begin
      if (!rst_a) begin
         total++;
         if (valid_a) begin
            vcnt_a++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected_valid got=%h expected none", word_a);
            end else begin
               exp_w = exp_q.pop_front();
               if (word_a !== exp_w) begin
                  bad++;
                  $display("FAIL sb_word got=%h exp=%h", word_a, exp_w);
               end
            end
         end else if (word_a !== 4'h0) begin
            bad++;
            $display("FAIL sb_word_idle got=%h exp=0", word_a);
         end
      end
   end

   // Leaves the bench at the negedge of cycle 0 after reset, with reset released.
   task automatic reset_a();
      @(negedge clk) rst_a = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; raw_a = 1'b0; raw_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
      repeat (3) @(negedge clk);
      total += 8;
      if (valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid_a got=%b exp=0", valid_a); end
      if (word_a  !== 4'h0) begin bad++; $display("FAIL rst_word_a got=%h exp=0", word_a); end
      if (ready_a !== 1'b0) begin bad++; $display("FAIL rst_ready_a got=%b exp=0", ready_a); end
      if (hf_a    !== 1'b0) begin bad++; $display("FAIL rst_hf_a got=%b exp=0", hf_a); end
      if (valid_b !== 1'b0) begin bad++; $display("FAIL rst_valid_b got=%b exp=0", valid_b); end
      if (word_b  !== 4'h0) begin bad++; $display("FAIL rst_word_b got=%h exp=0", word_b); end
      if (ready_b !== 1'b0) begin bad++; $display("FAIL rst_ready_b got=%b exp=0", ready_b); end
      if (hf_b    !== 1'b0) begin bad++; $display("FAIL rst_hf_b got=%b exp=0", hf_b); end
      rst_a = 1'b0;
   endtask

   // Pairs 01 10 10 01 00 11 01 10 give 0110. The word is full at cycle 10, and req there gives valid at 11.
   task automatic test_pack();
      logic [31:0] s;
      int v0;
      s = 32'h0000_6C96;
      reset_a();
      exp_q.push_back(vn_word(s, 16));
      v0 = vcnt_a;
      for (int c = 0; c < 20; c++) begin
         raw_a = (c < 16) ? s[c] : c[0];
         req_a = (c == 10 || c == 11);
         if (c == 9)  begin total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL pack_ready_early c=%0d got=%b exp=0", c, ready_a); end end
         if (c == 10) begin total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL pack_ready c=%0d got=%b exp=1", c, ready_a); end end
         if (c == 11) begin total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL pack_valid c=%0d got=%b exp=1", c, valid_a); end end
         if (c == 11) begin total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL pack_ready_clr c=%0d got=%b exp=0", c, ready_a); end end
         if (c == 12) begin total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL pack_valid_once c=%0d got=%b exp=0", c, valid_a); end end
         @(negedge clk);
      end
      total++;
      if (vcnt_a - v0 !== 1) begin bad++; $display("FAIL pack_valid_count got=%0d exp=1", vcnt_a - v0); end
   endtask

   // Req is held from reset. The first valid comes as soon as the word completes, and only once per req.
   task automatic test_req_early();
      int v0;
      req_a = 1'b1;
      reset_a();
      exp_q.push_back(vn_word(32'hAAAA_AAAA, 16));
      v0 = vcnt_a;
      for (int c = 0; c < 40; c++) begin
         raw_a = c[0];
         req_a = (c <= 11);
         total++;
         if (valid_a !== (c == 11)) begin
            bad++;
            $display("FAIL early_valid c=%0d got=%b exp=%b", c, valid_a, (c == 11));
         end
         @(negedge clk);
      end
      total++;
      if (vcnt_a - v0 !== 1) begin bad++; $display("FAIL early_valid_count got=%0d exp=1", vcnt_a - v0); end
   endtask

   // A stuck source with SAMPLE_DIV=8 gives its first strobe at cycle 7 with rct=1.
   // rct reaches 32 after the strobe at cycle 255, trips at 256, and health_fail shows at 257.
   task automatic test_stuck();
      int hf_cyc;
      logic saw_valid, saw_ready;
      hf_cyc = -1; saw_valid = 1'b0; saw_ready = 1'b0;
      raw_b = 1'b1; req_b = 1'b1;
      @(negedge clk) rst_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;
      for (int c = 0; c < 320; c++) begin
         if (c == 200) begin total++; if (hf_b !== 1'b0) begin bad++; $display("FAIL stuck_hf_early got=%b exp=0", hf_b); end end
         if (hf_b === 1'b1 && hf_cyc < 0) hf_cyc = c;
         if (valid_b !== 1'b0) saw_valid = 1'b1;
         if (ready_b !== 1'b0) saw_ready = 1'b1;
         @(negedge clk);
      end
      total += 4;
      if (hf_cyc != 257) begin bad++; $display("FAIL stuck_hf_cycle got=%0d exp=257", hf_cyc); end
      if (saw_valid)     begin bad++; $display("FAIL stuck_valid got=1 exp=0"); end
      if (saw_ready)     begin bad++; $display("FAIL stuck_ready got=1 exp=0"); end
      if (hf_b !== 1'b1) begin bad++; $display("FAIL stuck_hf_sticky got=%b exp=1", hf_b); end
   endtask

   // The word is full at cycle 10. From cycle 8 the raw input is constant, so rct=1 at cycle 11
   // and rct=32 at cycle 42. Req arrives exactly on that trip cycle and must not be served.
   task automatic test_trip_req();
      int v0;
      reset_a();
      v0 = vcnt_a;
      for (int c = 0; c < 60; c++) begin
         raw_a = (c < 8) ? c[0] : 1'b0;
         req_a = (c >= 42);
         if (c == 41) begin total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL trip_ready_pre got=%b exp=1", ready_a); end end
         if (c == 41) begin total++; if (hf_a !== 1'b0) begin bad++; $display("FAIL trip_hf_pre got=%b exp=0", hf_a); end end
         if (c == 43) begin total++; if (hf_a !== 1'b1) begin bad++; $display("FAIL trip_hf got=%b exp=1", hf_a); end end
         if (c == 43) begin total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL trip_ready got=%b exp=0", ready_a); end end
         @(negedge clk);
      end
      total++;
      if (vcnt_a - v0 !== 0) begin bad++; $display("FAIL trip_valid_count got=%0d exp=0", vcnt_a - v0); end
      req_a = 1'b0;
   endtask

   // Reset arrives with two bits packed (0,1). The next word must hold only the post-reset bits 1010.
   task automatic test_reset_mid();
      logic [31:0] pre, s;
      pre = 32'h0000_0006;
      s   = 32'h0000_0099;
      reset_a();
      for (int c = 0; c < 7; c++) begin
         raw_a = pre[c];
         req_a = 1'b0;
         @(negedge clk);
      end
      reset_a();
      exp_q.push_back(vn_word(s, 8));
      for (int c = 0; c < 16; c++) begin
         raw_a = (c < 8) ? s[c] : c[0];
         req_a = (c == 10 || c == 11);
         if (c == 9)  begin total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL mid_ready_early got=%b exp=0", ready_a); end end
         if (c == 10) begin total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", ready_a); end end
         if (c == 11) begin total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b exp=1", valid_a); end end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_pack();
      test_req_early();
      test_trip_req();
      test_reset_mid();
      test_stuck();
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
